// File: rtl/dcache_pkg.sv
// Shared types and address-split width helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } dcache_state_e;

    function automatic int off_width(input int line_words);
        return 2 + $clog2(line_words);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets, input int line_words);
        return addr_w - off_width(line_words) - idx_width(sets);
    endfunction

    // One extra bit so the counter is never zero-width when LINE_WORDS is 1.
    function automatic int beat_width(input int line_words);
        return $clog2(line_words) + 1;
    endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// Core-side and memory-side buses of the data cache.
interface dcache_cpu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W/8-1:0]   cpu_be;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_stall;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
                    input  cpu_rdata, cpu_stall);
    modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
                    output cpu_rdata, cpu_stall);
endinterface

interface dcache_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/dcache_dm_array.sv
// Valid/tag/data storage in flops: one combinational read port, one byte-enabled write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 20,
    localparam int IDX_W     = idx_width(SETS),
    localparam int FW        = IDX_W + $clog2(LINE_WORDS),
    localparam int BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FW-1:0]     rd_flat,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [FW-1:0]     wr_flat,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              set_en,
    input  logic [IDX_W-1:0]  set_idx,
    input  logic [TAG_W-1:0]  set_tag,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS*LINE_WORDS];
    logic [IDX_W-1:0]  rd_idx;

    // Flat word address is {index, word}; the set index is its upper part.
    assign rd_idx   = rd_flat[FW-1 -: IDX_W];
    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_flat];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[set_idx] <= 1'b1;
        end else if (inv_en) begin
            valid_q[inv_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_q[set_idx] <= set_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_flat][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, read-allocate data cache with stall and hit/miss statistics.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    dcache_cpu_if.slave      cpu,
    dcache_mem_if.master     mem,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS, LINE_WORDS);
    localparam int FW    = IDX_W + OFF_W - 2;
    localparam int BW    = beat_width(LINE_WORDS);
    localparam int BE_W  = DATA_W / 8;

    dcache_state_e     state_q, state_d;
    logic              mem_req_q, mem_we_q, just_filled_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [BW-1:0]     beat_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]  cpu_tag, rd_tag;
    logic [FW-1:0]     cpu_flat, mem_flat, arr_flat;
    logic [DATA_W-1:0] rd_data, arr_wdata, rdata_c;
    logic [BE_W-1:0]   arr_be;
    logic              rd_valid, hit, ack, last_beat, ld_hit, arr_we, set_en, inv_en;
    logic              unused_addr_lsb;

    assign cpu_tag         = cpu.cpu_addr[ADDR_W-1 -: TAG_W];
    assign cpu_flat        = cpu.cpu_addr[2 +: FW];
    assign mem_flat        = mem_addr_q[2 +: FW];
    assign hit             = rd_valid && (rd_tag == cpu_tag);
    assign ack             = mem.mem_ack && mem_req_q;
    assign last_beat       = (beat_q == BW'(LINE_WORDS - 1));
    assign unused_addr_lsb = ^cpu.cpu_addr[1:0];

    dcache_array #(
        .DATA_W     (DATA_W),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_flat  (cpu_flat),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (arr_we),
        .wr_flat  (arr_flat),
        .wr_data  (arr_wdata),
        .wr_be    (arr_be),
        .set_en   (set_en),
        .set_idx  (mem_flat[FW-1 -: IDX_W]),
        .set_tag  (mem_addr_q[ADDR_W-1 -: TAG_W]),
        .inv_en   (inv_en),
        .inv_idx  (cpu_flat[FW-1 -: IDX_W])
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ld_hit    = 1'b0;
        rdata_c   = '0;
        arr_we    = 1'b0;
        arr_flat  = cpu_flat;
        arr_wdata = cpu.cpu_wdata;
        arr_be    = cpu.cpu_be;
        set_en    = 1'b0;
        inv_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu.cpu_req) begin
                    if (cpu.cpu_we) begin
                        state_d = WRITE;
                        arr_we  = hit;
                    end else if (hit) begin
                        ld_hit  = 1'b1;
                        rdata_c = rd_data;
                    end else begin
                        // Line is invalid until its last beat lands, so an abort leaves it unusable.
                        state_d = REFILL;
                        inv_en  = 1'b1;
                    end
                end
            end
            REFILL: begin
                arr_we    = ack;
                arr_flat  = mem_flat;
                arr_wdata = mem.mem_rdata;
                arr_be    = '1;
                if (ack && last_beat) begin
                    set_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu.cpu_rdata = rdata_c;
    assign cpu.cpu_stall = cpu.cpu_req && !ld_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            beat_q        <= '0;
            just_filled_q <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            just_filled_q <= 1'b0;
            // The re-presented load right after a refill belongs to the miss already counted.
            if (ld_hit && !just_filled_q) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (state_d == REFILL) begin
                        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {cpu.cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_be_q   <= '1;
                        beat_q     <= '0;
                    end else if (state_d == WRITE) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {cpu.cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= cpu.cpu_wdata;
                        mem_be_q    <= cpu.cpu_be;
                    end
                end
                REFILL: begin
                    if (ack) begin
                        beat_q     <= beat_q + BW'(1);
                        mem_addr_q <= mem_addr_q + ADDR_W'(4);
                        if (last_beat) begin
                            mem_req_q     <= 1'b0;
                            just_filled_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (ack) mem_req_q <= 1'b0;
                end
                default: mem_req_q <= 1'b0;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule
